handshake_const_sink: RTL and testbench
=======================================

# handshake_const_sink

Consumer-side counterpart of the constant-source handshake units. Accepts a data token on an elastic valid/ready channel, discards the payload, and re-emits a dataless control token through a 2-slot buffer; it closes a data path into a control path, e.g. a loop-exit or a done signal. Optionally checks every accepted payload against a compile-time expected constant and latches the first mismatch for debug. Counts accepted tokens.

## Interface

Parameters:
- DATA_WIDTH, 32, width of the incoming payload.
- EXPECTED, 32'h0000_0010, value every payload is compared against; only the low DATA_WIDTH bits are used.
- COUNT_WIDTH, 16, width of the accepted-token counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; asserting it (0) clears all state immediately.
- ins  input  DATA_WIDTH  payload of the input data channel.
- ins_valid  input  1  input token present.
- ins_ready  output  1  block can accept an input token.
- outs_valid  output  1  control token available.
- outs_ready  input  1  downstream consumes the control token.
- token_count  output  COUNT_WIDTH  number of input tokens accepted since reset, modulo 2^COUNT_WIDTH.
- err  output  1  sticky mismatch flag.
- err_data  output  DATA_WIDTH  payload of the first mismatching token.

## Operation

- Input transfer: ins_valid && ins_ready at a rising edge. Output transfer: outs_valid && outs_ready at a rising edge.
- Occupancy register occ, range 0..2. Buffer slots hold no data.
- occ update per edge: +1 on input transfer only; -1 on output transfer only; unchanged on both or neither.
- ins_ready = (occ != 2). outs_valid = (occ != 0). Both are decoded from registered state only; there is no combinational path from outs_ready to ins_ready or from ins_valid to outs_valid.
- token_count increments on every input transfer and wraps from all-ones to 0. It is independent of the output side.
- Check, enabled by the configuration macro: on an input transfer with ins != EXPECTED[DATA_WIDTH-1:0] while err == 0, set err = 1 and load err_data = ins. Later mismatches change nothing. err clears only on reset.
- Tokens are never dropped or duplicated. Output tokens equal input tokens minus occ at all times.

## Timing

- Reset values: occ = 0, so ins_ready = 1 and outs_valid = 0. token_count = 0, err = 0, err_data = 0.
- Latency: a token accepted at edge N gives outs_valid = 1 after edge N, so it can leave at edge N+1.
- Throughput: 1 token/cycle sustained while outs_ready is held at 1.
- Full (occ == 2): ins_ready = 0. A simultaneous output transfer frees a slot, but ins_ready rises only after that edge.
- Empty (occ == 0): outs_valid = 0. Any outs_ready value is ignored.
- Reset mid-operation: buffered tokens are lost, counters and flags clear asynchronously, and outputs take their reset values without waiting for clk.
- Release of reset is expected to be synchronous to clk upstream. The block performs no transfer on the first edge at which rst is sampled 0.

## Configuration

- Macro: HANDSHAKE_CONST_SINK_CHECK_EN.
- Defined: compare logic, err register and err_data register are built as described above.
- Not defined: no comparator or error registers are built. err is tied to 0 and err_data to 0. The handshake and token_count behave identically in both builds.

## Test plan

- Reset then idle: rst = 0 for 3 cycles, then 1, with ins_valid = 0 -> ins_ready = 1, outs_valid = 0, token_count = 0, err = 0 throughout.
- Streaming: ins_valid = 1, ins = 0x10 and outs_ready = 1 for 100 cycles -> first outs_valid one cycle after first accept, 100 output transfers, token_count = 100, err = 0.
- Backpressure: outs_ready = 0 and 3 tokens offered -> 2 accepted, ins_ready = 0 after the second accept. Then outs_ready = 1 -> the third token is accepted and exactly 3 output transfers occur.
- Mismatch (macro defined): tokens 0x10, 0x7, 0x10, 0x9 -> err rises after the 0x7 accept, err_data = 0x7 and stays 0x7 after 0x9. Same stimulus with the macro undefined -> err = 0, err_data = 0.
- Counter wrap and async reset: COUNT_WIDTH = 4, accept 17 tokens -> token_count = 1. Then drop rst mid-cycle with occ = 2 -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/handshake_const_sink_if.sv
// -----------------------------------------------------------------------------
// handshake_const_sink_if
//
// Purpose:
//    Bundles the two elastic channels seen by handshake_const_sink. The first
//    channel carries a data token into the sink. The second channel carries a
//    dataless control token out of the sink.
//
// Signals:
//    ins         payload of the incoming data token (DATA_WIDTH bits)
//    ins_valid   upstream presents a data token
//    ins_ready   sink can take a data token
//    outs_valid  sink presents a control token
//    outs_ready  downstream takes the control token
//
// Modports:
//    master  environment side: drives ins/ins_valid/outs_ready
//    slave   sink side: drives ins_ready/outs_valid
// -----------------------------------------------------------------------------
interface handshake_const_sink_if #(
   parameter int unsigned DATA_WIDTH = 32
);

   logic [DATA_WIDTH-1:0] ins;
   logic                  ins_valid;
   logic                  ins_ready;
   logic                  outs_valid;
   logic                  outs_ready;

   modport master (
      output ins,
      output ins_valid,
      output outs_ready,
      input  ins_ready,
      input  outs_valid
   );

   modport slave (
      input  ins,
      input  ins_valid,
      input  outs_ready,
      output ins_ready,
      output outs_valid
   );

endinterface

// File: rtl/handshake_const_sink.sv
// -----------------------------------------------------------------------------
// handshake_const_sink
//
// Purpose:
//    Consumes data tokens on an elastic valid/ready channel and drops their
//    payload. Each accepted token is re-emitted as a dataless control token
//    through a two-slot buffer. Only the buffer occupancy is stored, because
//    the slots carry no data. Accepted tokens are counted. An optional checker
//    compares every accepted payload with EXPECTED and latches the first
//    payload that differs.
//
// Configuration macro:
//    HANDSHAKE_CONST_SINK_CHECK_EN  when defined, the payload checker and the
//                                   err/err_data registers are built. When it
//                                   is not defined, err and err_data are
//                                   tied to 0.
//
// Parameters:
//    DATA_WIDTH   payload width
//    EXPECTED     reference payload; only the low DATA_WIDTH bits are used
//    COUNT_WIDTH  width of the accepted-token counter
//
// Ports:
//    clk          rising-edge clock
//    rst          asynchronous, active-low reset
//    bus          slave side of handshake_const_sink_if (ins, ins_valid,
//                 ins_ready, outs_valid, outs_ready)
//    token_count  number of accepted tokens, modulo 2^COUNT_WIDTH
//    err          sticky payload-mismatch flag
//    err_data     payload of the first mismatching token
// -----------------------------------------------------------------------------
module handshake_const_sink #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter logic [31:0] EXPECTED    = 32'h0000_0010,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   handshake_const_sink_if.slave  bus,
   output logic [COUNT_WIDTH-1:0] token_count,
   output logic                   err,
   output logic [DATA_WIDTH-1:0]  err_data
);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   occ_e                   occ_q;
   occ_e                   occ_d;
   logic                   insReady;
   logic                   outsValid;
   logic                   inXfer;
   logic                   outXfer;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] count_d;

   // The handshake outputs come only from the registered occupancy. A change
   // on outs_ready or ins_valid therefore cannot reach the opposite side
   // within the same cycle. This is what lets these sinks be chained
   // without creating combinational loops.
   always_comb begin
      insReady  = 1'b1;
      outsValid = 1'b0;
      unique case (occ_q)
         OCC_EMPTY: begin
            insReady  = 1'b1;
            outsValid = 1'b0;
         end
         OCC_ONE: begin
            insReady  = 1'b1;
            outsValid = 1'b1;
         end
         OCC_FULL: begin
            insReady  = 1'b0;
            outsValid = 1'b1;
         end
         default: begin
            insReady  = 1'b1;
            outsValid = 1'b0;
         end
      endcase
   end

   assign inXfer         = bus.ins_valid  && insReady;
   assign outXfer        = outsValid      && bus.outs_ready;
   assign bus.ins_ready  = insReady;
   assign bus.outs_valid = outsValid;

   // Next occupancy. The buffer grows when only the input side moves and
   // shrinks when only the output side moves. When both sides move, or
   // neither does, the occupancy stays the same. An input transfer cannot
   // occur when the buffer is full, and an output transfer cannot occur
   // when it is empty, so those cases are not coded.
   always_comb begin
      occ_d = occ_q;
      unique case (occ_q)
         OCC_EMPTY: begin
            if (inXfer) occ_d = OCC_ONE;
         end
         OCC_ONE: begin
            if (inXfer && !outXfer)      occ_d = OCC_FULL;
            else if (!inXfer && outXfer) occ_d = OCC_EMPTY;
         end
         OCC_FULL: begin
            if (outXfer) occ_d = OCC_ONE;
         end
         default: occ_d = OCC_EMPTY;
      endcase
   end

   // The accepted-token counter only watches the input side and wraps
   // naturally at 2^COUNT_WIDTH.
   always_comb begin
      count_d = count_q;
      if (inXfer) count_d = count_q + COUNT_WIDTH'(1);
   end

   // Occupancy and counter registers. Asserting reset empties the buffer at
   // once, and any buffered control tokens are lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q   <= OCC_EMPTY;
         count_q <= '0;
      end else begin
         occ_q   <= occ_d;
         count_q <= count_d;
      end
   end

   assign token_count = count_q;

`ifdef HANDSHAKE_CONST_SINK_CHECK_EN
   localparam logic [DATA_WIDTH-1:0] EXPECTED_VALUE = DATA_WIDTH'(EXPECTED);

   logic                  errFlag_q;
   logic                  errFlag_d;
   logic [DATA_WIDTH-1:0] errData_q;
   logic [DATA_WIDTH-1:0] errData_d;

   // The first accepted payload that differs from the reference is kept for
   // debug. After the flag is set, the captured value stays frozen until
   // reset, so later mismatches cannot overwrite the original culprit.
   always_comb begin
      errFlag_d = errFlag_q;
      errData_d = errData_q;
      if (inXfer && !errFlag_q && (bus.ins != EXPECTED_VALUE)) begin
         errFlag_d = 1'b1;
         errData_d = bus.ins;
      end
   end

   // Checker registers. Only reset clears them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         errFlag_q <= 1'b0;
         errData_q <= '0;
      end else begin
         errFlag_q <= errFlag_d;
         errData_q <= errData_d;
      end
   end

   assign err      = errFlag_q;
   assign err_data = errData_q;
`else
   // No checker is built in this configuration.
   assign err      = 1'b0;
   assign err_data = '0;
`endif

endmodule

// File: tb/tb_handshake_const_sink.sv
// -----------------------------------------------------------------------------
// tb_handshake_const_sink
//
// Purpose:
//    Drives two sinks with identical stimulus. One has a 16-bit counter and
//    the other a 4-bit counter, so that counter wrap is observed. Their
//    outputs are compared against a token-accounting reference model. The
//    model tracks only the totals of accepted and emitted tokens. From these
//    it derives the occupancy, readiness, validity, the counter value and
//    the first-mismatch record.
// -----------------------------------------------------------------------------
module tb_handshake_const_sink;

   localparam logic [31:0] EXP_VAL = 32'h0000_0010;

`ifdef HANDSHAKE_CONST_SINK_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] insData;
   logic        insValid;
   logic        outsReady;

   logic [15:0] countA;
   logic [3:0]  countB;
   logic        errA;
   logic        errB;
   logic [31:0] errDataA;
   logic [31:0] errDataB;

   int checks;
   int errors;

   // Reference model state.
   int          accepted;
   int          emitted;
   bit          errExp;
   logic [31:0] errDataExp;
   int          dutOutXfers;

   handshake_const_sink_if #(.DATA_WIDTH(32)) busA ();
   handshake_const_sink_if #(.DATA_WIDTH(32)) busB ();

   assign busA.ins        = insData;
   assign busA.ins_valid  = insValid;
   assign busA.outs_ready = outsReady;
   assign busB.ins        = insData;
   assign busB.ins_valid  = insValid;
   assign busB.outs_ready = outsReady;

   handshake_const_sink #(
      .DATA_WIDTH (32),
      .EXPECTED   (EXP_VAL),
      .COUNT_WIDTH(16)
   ) dutA (
      .clk        (clk),
      .rst        (rst),
      .bus        (busA),
      .token_count(countA),
      .err        (errA),
      .err_data   (errDataA)
   );

   handshake_const_sink #(
      .DATA_WIDTH (32),
      .EXPECTED   (EXP_VAL),
      .COUNT_WIDTH(4)
   ) dutB (
      .clk        (clk),
      .rst        (rst),
      .bus        (busB),
      .token_count(countB),
      .err        (errB),
      .err_data   (errDataB)
   );

   // 10-time-unit clock. Rising edges occur at 5, 15, 25 and so on.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point. It counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Compares every DUT output with the model's view of the current state.
   task automatic checkAll();
      int occ;
      occ = accepted - emitted;
      checkOutput("ins_ready_a",   32'(busA.ins_ready),  32'(occ != 2));
      checkOutput("outs_valid_a",  32'(busA.outs_valid), 32'(occ != 0));
      checkOutput("ins_ready_b",   32'(busB.ins_ready),  32'(occ != 2));
      checkOutput("outs_valid_b",  32'(busB.outs_valid), 32'(occ != 0));
      checkOutput("count_a",       32'(countA),          32'(accepted % 65536));
      checkOutput("count_b",       32'(countB),          32'(accepted % 16));
      checkOutput("err_a",         32'(errA),            32'(errExp));
      checkOutput("err_b",         32'(errB),            32'(errExp));
      checkOutput("err_data_a",    errDataA,             errDataExp);
      checkOutput("err_data_b",    errDataB,             errDataExp);
   endtask

   task automatic modelReset();
      accepted   = 0;
      emitted    = 0;
      errExp     = 1'b0;
      errDataExp = '0;
   endtask

   // Runs one clock cycle. Inputs are driven just after a rising edge, and
   // outputs are checked on the falling edge. The model then advances by
   // the transfers allowed at the next rising edge.
   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
      int occ;
      bit inX;
      bit outX;
      insValid  = v;
      insData   = d;
      outsReady = r;
      @(negedge clk);
      checkAll();
      if (busA.outs_valid && r) dutOutXfers++;
      occ  = accepted - emitted;
      inX  = v && (occ < 2);
      outX = r && (occ > 0);
      @(posedge clk);
      #1;
      if (inX) begin
         accepted++;
         if (CHECK_EN && !errExp && (d != EXP_VAL)) begin
            errExp     = 1'b1;
            errDataExp = d;
         end
      end
      if (outX) emitted++;
   endtask

   // Holds reset for three cycles while idle and checks the reset values
   // each cycle. Reset is released just after a rising edge.
   task automatic applyReset();
      insValid  = 1'b0;
      outsReady = 1'b0;
      rst       = 1'b0;
      modelReset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkAll();
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      dutOutXfers = 0;
      insData     = '0;
      insValid    = 1'b0;
      outsReady   = 1'b0;
      rst         = 1'b0;
      modelReset();
      #1;
      @(posedge clk);
      #1;
      applyReset();

      // Idle after reset.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, EXP_VAL, 1'b0);

      // Streaming at full rate.
      dutOutXfers = 0;
      applyStimulus(1'b1, EXP_VAL, 1'b1);
      checkOutput("first_outs_valid", 32'(busA.outs_valid), 32'd1);
      for (int i = 1; i < 100; i++) applyStimulus(1'b1, EXP_VAL, 1'b1);
      applyStimulus(1'b0, EXP_VAL, 1'b1);
      checkOutput("stream_out_xfers", 32'(dutOutXfers), 32'd100);
      checkOutput("stream_count_a",   32'(countA),      32'd100);
      checkOutput("stream_count_b",   32'(countB),      32'd4);

      // Backpressure: only two of three offered tokens fit.
      dutOutXfers = 0;
      applyStimulus(1'b1, EXP_VAL, 1'b0);
      applyStimulus(1'b1, EXP_VAL, 1'b0);
      checkOutput("bp_full_ready", 32'(busA.ins_ready), 32'd0);
      applyStimulus(1'b1, EXP_VAL, 1'b0);
      checkOutput("bp_held_count", 32'(countA), 32'd102);
      begin
         int tries;
         tries = 0;
         while (accepted < 103 && tries < 10) begin
            applyStimulus(1'b1, EXP_VAL, 1'b1);
            tries++;
         end
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, EXP_VAL, 1'b1);
      checkOutput("bp_count",     32'(countA),      32'd103);
      checkOutput("bp_out_xfers", 32'(dutOutXfers), 32'd3);

      // Mismatching payloads.
      applyStimulus(1'b1, 32'h10, 1'b1);
      applyStimulus(1'b1, 32'h07, 1'b1);
      applyStimulus(1'b1, 32'h10, 1'b1);
      applyStimulus(1'b1, 32'h09, 1'b1);
      applyStimulus(1'b0, EXP_VAL, 1'b1);
      checkOutput("mismatch_err_data", errDataA, CHECK_EN ? 32'h7 : 32'h0);
      checkOutput("mismatch_err",      32'(errA), CHECK_EN ? 32'd1 : 32'd0);

      // Randomised traffic, with mostly matching payloads.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] d;
         d = ($urandom_range(0, 5) == 0) ? $urandom : EXP_VAL;
         applyStimulus(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
      end

      // Counter wrap on the 4-bit instance.
      applyReset();
      for (int i = 0; i < 17; i++) applyStimulus(1'b1, EXP_VAL, 1'b1);
      checkOutput("wrap_count_b", 32'(countB), 32'd1);
      checkOutput("wrap_count_a", 32'(countA), 32'd17);

      // Fill the buffer, then assert reset in the middle of a cycle.
      applyStimulus(1'b1, 32'h5, 1'b0);
      applyStimulus(1'b1, EXP_VAL, 1'b0);
      checkOutput("pre_reset_full", 32'(busA.ins_ready), 32'd0);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_ins_ready",  32'(busA.ins_ready),  32'd1);
      checkOutput("async_outs_valid", 32'(busA.outs_valid), 32'd0);
      checkOutput("async_count_a",    32'(countA),          32'd0);
      checkOutput("async_count_b",    32'(countB),          32'd0);
      checkOutput("async_err",        32'(errA),            32'd0);
      checkOutput("async_err_data",   errDataA,             32'd0);
      @(posedge clk);
      #1;
      applyReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, EXP_VAL, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
